// File: rtl/rib_arb_if.sv
// RIB arbiter bus bundle: per-master request/response handshakes, the muxed
// slave handshakes, and the arbiter's grant/status outputs.
//   m_req_vld_i [4] / m_rsp_rdy_i [4] : per-master request valid / response ready
//   s_req_rdy_i / s_rsp_vld_i         : addressed-slave request ready / response valid
//   grant_o [4] / grant_idx_o [2]     : one-hot grant and its binary index
//   busy_o / timeout_o                : grant held / watchdog fired pulse
// Modport slave is the arbiter side; modport master is the requester/slave environment.
interface rib_arb_if;
  localparam int unsigned MST_W = 4;
  localparam int unsigned IDX_W = 2;

  logic [MST_W-1:0] m_req_vld_i;
  logic [MST_W-1:0] m_rsp_rdy_i;
  logic             s_req_rdy_i;
  logic             s_rsp_vld_i;
  logic [MST_W-1:0] grant_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic             busy_o;
  logic             timeout_o;

  modport slave (
    input  m_req_vld_i, m_rsp_rdy_i, s_req_rdy_i, s_rsp_vld_i,
    output grant_o, grant_idx_o, busy_o, timeout_o
  );

  modport master (
    output m_req_vld_i, m_rsp_rdy_i, s_req_rdy_i, s_rsp_vld_i,
    input  grant_o, grant_idx_o, busy_o, timeout_o
  );
endinterface

// File: rtl/rib_arbiter.sv
// Four-master RIB arbiter. Grants one master at a time and holds the grant for
// a full request/response transaction; round-robin or fixed-priority selection;
// a watchdog force-releases a transaction that never completes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rib_arb_if.slave (requests/handshakes in, grant/status out)
// All outputs are registered.
module rib_arbiter #(
  parameter int unsigned MASTER_NUM     = 4,
  parameter bit          RR_EN          = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic      clk,
  input  logic      rst_n,
  rib_arb_if.slave  bus
);

  localparam int unsigned NM      = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned WDOG_W  = 16;
  localparam logic [NM-1:0]     REQ_MASK  = NM'((1 << MASTER_NUM) - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MASTER_NUM - 1);
  localparam bit                WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_EN ? WDOG_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // First requester scanning ptr, ptr+1, ... modulo MASTER_NUM; result is {found, idx}.
  function automatic logic [IDX_W:0] pick(input logic [NM-1:0] req, input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    logic [IDX_W:0] idx;
    res = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      idx = (IDX_W+1)'(ptr) + (IDX_W+1)'(i);
      if (idx >= (IDX_W+1)'(MASTER_NUM)) idx = idx - (IDX_W+1)'(MASTER_NUM);
      if ((i < MASTER_NUM) && !res[IDX_W] && req[idx[IDX_W-1:0]]) res = {1'b1, idx[IDX_W-1:0]};
    end
    return res;
  endfunction

  state_e             state_q, state_d;
  logic [NM-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;

  logic [NM-1:0]      req_m;
  logic [IDX_W-1:0]   nxt_ptr;
  logic [IDX_W:0]     pick_idle;
  logic [IDX_W:0]     pick_done;
  logic               wdog_hit;
  logic               cmpl;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state: selection, transaction tracking, watchdog.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;

    req_m     = bus.m_req_vld_i & REQ_MASK;
    nxt_ptr   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    pick_idle = pick(req_m, RR_EN ? ptr_q : '0);
    // After completion the pointer has already advanced past the finishing master.
    pick_done = pick(req_m, RR_EN ? nxt_ptr : '0);
    wdog_hit  = WDOG_EN && (wdog_q == WDOG_LAST);
    cmpl      = bus.s_rsp_vld_i & bus.m_rsp_rdy_i[idx_q];

    unique case (state_q)
      ST_IDLE: begin
        if (pick_idle[IDX_W]) begin
          state_d = ST_REQ;
          idx_d   = pick_idle[IDX_W-1:0];
          grant_d = NM'(1) << pick_idle[IDX_W-1:0];
          busy_d  = 1'b1;
          wdog_d  = '0;
        end
      end

      ST_REQ: begin
        wdog_d = wdog_q + WDOG_W'(1);
        // Withdraw beats timeout: the master has already let go, nothing is hung.
        if (!req_m[idx_q] || wdog_hit) begin
          state_d = ST_IDLE;
          grant_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
          wdog_d  = '0;
          if (req_m[idx_q]) begin
            tmo_d = 1'b1;
            ptr_d = nxt_ptr;
          end
        end else if (bus.s_req_rdy_i) begin
          state_d = ST_RSP;
        end
      end

      ST_RSP: begin
        wdog_d = wdog_q + WDOG_W'(1);
        // Completion beats timeout in the same cycle.
        if (cmpl) begin
          ptr_d = nxt_ptr;
          if (pick_done[IDX_W]) begin
            state_d = ST_REQ;
            idx_d   = pick_done[IDX_W-1:0];
            grant_d = NM'(1) << pick_done[IDX_W-1:0];
            busy_d  = 1'b1;
            wdog_d  = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            idx_d   = '0;
            busy_d  = 1'b0;
            wdog_d  = '0;
          end
        end else if (wdog_hit) begin
          state_d = ST_IDLE;
          grant_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
          wdog_d  = '0;
          tmo_d   = 1'b1;
          ptr_d   = nxt_ptr;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
        wdog_d  = '0;
      end
    endcase
  end

  assign bus.grant_o     = grant_q;
  assign bus.grant_idx_o = idx_q;
  assign bus.busy_o      = busy_q;
  assign bus.timeout_o   = tmo_q;

endmodule

// File: tb/tb_rib_arbiter.sv
// Scoreboard bench for rib_arbiter. Instance A: round-robin, 4 masters,
// watchdog 8. Instance B: fixed priority, 3 masters, watchdog disabled.
// Stimulus pushes expected output events {cycle, grant, idx, busy, timeout};
// monitors pop and compare whenever grant changes or timeout_o is high.
module tb_rib_arbiter;

  typedef struct packed {
    logic [15:0] cyc;
    logic [3:0]  grant;
    logic [1:0]  idx;
    logic        busy;
    logic        tmo;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  ev_t  qa[$];
  ev_t  qb[$];
  logic [3:0] prev_ga;
  logic [3:0] prev_gb;

  rib_arb_if ifa ();
  rib_arb_if ifb ();

  rib_arbiter #(.MASTER_NUM(4), .RR_EN(1'b1), .TIMEOUT_CYCLES(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  rib_arbiter #(.MASTER_NUM(3), .RR_EN(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic cmp_ev(input string nm, input ev_t act, input ev_t exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got cyc=%0d grant=%b idx=%0d busy=%b tmo=%b exp cyc=%0d grant=%b idx=%0d busy=%b tmo=%b",
               nm, act.cyc, act.grant, act.idx, act.busy, act.tmo,
               exp.cyc, exp.grant, exp.idx, exp.busy, exp.tmo);
    end
  endtask

  task automatic exp_a(input int c, input logic [3:0] g, input logic [1:0] i, input logic b, input logic t);
    ev_t e;
    e = '{cyc: 16'(c), grant: g, idx: i, busy: b, tmo: t};
    qa.push_back(e);
  endtask

  task automatic exp_b(input int c, input logic [3:0] g, input logic [1:0] i, input logic b, input logic t);
    ev_t e;
    e = '{cyc: 16'(c), grant: g, idx: i, busy: b, tmo: t};
    qb.push_back(e);
  endtask

  // Wait until the falling edge at which the posedge count equals n.
  task automatic go(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor A.
  initial prev_ga = '0;
  always @(negedge clk) begin
    ev_t got;
    if ((ifa.grant_o != prev_ga) || ifa.timeout_o) begin
      got = '{cyc: 16'(cyc), grant: ifa.grant_o, idx: ifa.grant_idx_o, busy: ifa.busy_o, tmo: ifa.timeout_o};
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ev_a_unexpected cyc=%0d grant=%b tmo=%b", cyc, ifa.grant_o, ifa.timeout_o);
      end else begin
        cmp_ev("ev_a", got, qa.pop_front());
      end
    end
    prev_ga = ifa.grant_o;
  end

  // Monitor B.
  initial prev_gb = '0;
  always @(negedge clk) begin
    ev_t got;
    if ((ifb.grant_o != prev_gb) || ifb.timeout_o) begin
      got = '{cyc: 16'(cyc), grant: ifb.grant_o, idx: ifb.grant_idx_o, busy: ifb.busy_o, tmo: ifb.timeout_o};
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ev_b_unexpected cyc=%0d grant=%b tmo=%b", cyc, ifb.grant_o, ifb.timeout_o);
      end else begin
        cmp_ev("ev_b", got, qb.pop_front());
      end
    end
    prev_gb = ifb.grant_o;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int b;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ifa.m_req_vld_i = '0; ifa.m_rsp_rdy_i = '0; ifa.s_req_rdy_i = 1'b0; ifa.s_rsp_vld_i = 1'b0;
    ifb.m_req_vld_i = '0; ifb.m_rsp_rdy_i = '0; ifb.s_req_rdy_i = 1'b0; ifb.s_rsp_vld_i = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant_a", int'(ifa.grant_o), 0);
    chk("rst_idx_a",   int'(ifa.grant_idx_o), 0);
    chk("rst_busy_a",  int'(ifa.busy_o), 0);
    chk("rst_tmo_a",   int'(ifa.timeout_o), 0);
    chk("rst_grant_b", int'(ifb.grant_o), 0);
    rst_n = 1'b1;

    // Single master: grant 1 cycle after request, release on completion.
    b = cyc;
    ifa.m_req_vld_i = 4'b0010;
    exp_a(b+1, 4'b0010, 2'd1, 1'b1, 1'b0);
    go(b+1); ifa.s_req_rdy_i = 1'b1;
    go(b+2); ifa.s_req_rdy_i = 1'b0; ifa.m_req_vld_i = 4'b0000;
    go(b+3); ifa.s_rsp_vld_i = 1'b1; ifa.m_rsp_rdy_i = 4'b0010;
    exp_a(b+4, 4'b0000, 2'd0, 1'b0, 1'b0);
    go(b+4); ifa.s_rsp_vld_i = 1'b0; ifa.m_rsp_rdy_i = 4'b0000;
    go(b+6);

    // Reset pulse to bring the pointer back to 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all masters requesting; s_rsp_vld held high is ignored in REQ.
    b = cyc;
    ifa.m_req_vld_i = 4'b1111; ifa.s_req_rdy_i = 1'b1;
    ifa.s_rsp_vld_i = 1'b1;    ifa.m_rsp_rdy_i = 4'b1111;
    exp_a(b+1, 4'b0001, 2'd0, 1'b1, 1'b0);
    exp_a(b+3, 4'b0010, 2'd1, 1'b1, 1'b0);
    exp_a(b+5, 4'b0100, 2'd2, 1'b1, 1'b0);
    exp_a(b+7, 4'b1000, 2'd3, 1'b1, 1'b0);
    exp_a(b+9, 4'b0001, 2'd0, 1'b1, 1'b0);
    go(b+9);
    ifa.m_req_vld_i = 4'b0000; ifa.s_req_rdy_i = 1'b0;
    ifa.s_rsp_vld_i = 1'b0;    ifa.m_rsp_rdy_i = 4'b0000;
    exp_a(b+10, 4'b0000, 2'd0, 1'b0, 1'b0);
    go(b+12);

    // Pointer unchanged by withdraw (still 0), then completion colliding with timeout.
    b = cyc;
    ifa.m_req_vld_i = 4'b0011;
    exp_a(b+1, 4'b0001, 2'd0, 1'b1, 1'b0);
    go(b+1); ifa.s_req_rdy_i = 1'b1;
    go(b+2); ifa.s_req_rdy_i = 1'b0; ifa.m_req_vld_i = 4'b0000;
    go(b+8); ifa.s_rsp_vld_i = 1'b1; ifa.m_rsp_rdy_i = 4'b0001;
    exp_a(b+9, 4'b0000, 2'd0, 1'b0, 1'b0);
    go(b+9); ifa.s_rsp_vld_i = 1'b0; ifa.m_rsp_rdy_i = 4'b0000;
    go(b+12);

    // Watchdog: pointer is 1, master 2 wins, hangs, times out 8 cycles later, master 3 next.
    b = cyc;
    ifa.m_req_vld_i = 4'b1100;
    exp_a(b+1, 4'b0100, 2'd2, 1'b1, 1'b0);
    go(b+1); ifa.s_req_rdy_i = 1'b1;
    go(b+2); ifa.s_req_rdy_i = 1'b0;
    exp_a(b+9,  4'b0000, 2'd0, 1'b0, 1'b1);
    exp_a(b+10, 4'b1000, 2'd3, 1'b1, 1'b0);
    go(b+10); ifa.m_req_vld_i = 4'b0000;
    exp_a(b+11, 4'b0000, 2'd0, 1'b0, 1'b0);
    go(b+13);

    // Async reset mid-RSP; pointer (3) must restart at 0.
    b = cyc;
    ifa.m_req_vld_i = 4'b0001;
    exp_a(b+1, 4'b0001, 2'd0, 1'b1, 1'b0);
    go(b+1); ifa.s_req_rdy_i = 1'b1;
    go(b+2); ifa.s_req_rdy_i = 1'b0;
    exp_a(b+3, 4'b0000, 2'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", int'(ifa.grant_o), 0);
    chk("async_idx",   int'(ifa.grant_idx_o), 0);
    chk("async_busy",  int'(ifa.busy_o), 0);
    chk("async_tmo",   int'(ifa.timeout_o), 0);
    go(b+4); rst_n = 1'b1; ifa.m_req_vld_i = 4'b1010;
    exp_a(b+5, 4'b0010, 2'd1, 1'b1, 1'b0);
    go(b+5); ifa.m_req_vld_i = 4'b0000;
    exp_a(b+6, 4'b0000, 2'd0, 1'b0, 1'b0);
    go(b+8);

    // Fixed priority, 3 masters: bit 3 ignored, late master 0 wins next, no watchdog.
    b = cyc;
    ifb.m_req_vld_i = 4'b1000;
    go(b+3); ifb.m_req_vld_i = 4'b1100;
    exp_b(b+4, 4'b0100, 2'd2, 1'b1, 1'b0);
    b = b + 3;
    go(b+1);  ifb.s_req_rdy_i = 1'b1;
    go(b+2);  ifb.s_req_rdy_i = 1'b0; ifb.m_req_vld_i = 4'b1101;
    go(b+12); ifb.s_rsp_vld_i = 1'b1; ifb.m_rsp_rdy_i = 4'b0100;
    exp_b(b+13, 4'b0001, 2'd0, 1'b1, 1'b0);
    go(b+13); ifb.s_rsp_vld_i = 1'b0; ifb.m_rsp_rdy_i = 4'b0000; ifb.s_req_rdy_i = 1'b1;
    go(b+14); ifb.s_req_rdy_i = 1'b0; ifb.m_req_vld_i = 4'b1100;
              ifb.s_rsp_vld_i = 1'b1; ifb.m_rsp_rdy_i = 4'b0001;
    exp_b(b+15, 4'b0100, 2'd2, 1'b1, 1'b0);
    go(b+15); ifb.m_req_vld_i = 4'b0000; ifb.s_rsp_vld_i = 1'b0; ifb.m_rsp_rdy_i = 4'b0000;
    exp_b(b+16, 4'b0000, 2'd0, 1'b0, 1'b0);
    go(b+19);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
